// File: rtl/db_bounce_gen.sv
// Mechanical-contact bounce emulator: turns a clean requested level into a bouncing button
// waveform with LFSR-randomised segment lengths, then reports when the line has settled.
module db_bounce_gen #(
  parameter int unsigned BOUNCES   = 4,
  parameter int unsigned MAX_HOLD  = 7,
  parameter int unsigned SETTLE    = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic target,
  input  logic bounce_en,
  output logic button,
  output logic busy,
  output logic done
);

  localparam int unsigned HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned TW = (BOUNCES == 0) ? 1 : $clog2(2 * BOUNCES + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);

  localparam logic [HW-1:0] HOLD_MAX    = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
  localparam logic [TW-1:0] TGL_ONE     = TW'(1);
  localparam logic [TW-1:0] TGL_LAST    = (BOUNCES == 0) ? TW'(0) : TW'(2 * BOUNCES - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StBounce,
    StSettle
  } state_e;

  state_e        state_q, state_d;
  logic          button_q, button_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          level_q, level_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tgl_q, tgl_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [7:0]    lfsr_q;
  logic          lfsr_fb;
  logic [HW-1:0] seg_raw;
  logic [HW-1:0] seg_len;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Free-running regardless of FSM state, so segment lengths depend on when a change arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  // Clamp the raw LFSR slice into 1..MAX_HOLD.
  always_comb begin
    seg_raw = lfsr_q[HW-1:0];
    if (seg_raw == '0) begin
      seg_len = HOLD_ONE;
    end else if (seg_raw > HOLD_MAX) begin
      seg_len = HOLD_MAX;
    end else begin
      seg_len = seg_raw;
    end
  end

  always_comb begin
    state_d  = state_q;
    button_d = button_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    level_d  = level_q;
    hold_d   = hold_q;
    tgl_d    = tgl_q;
    settle_d = settle_q;

    case (state_q)
      StIdle: begin
        if (target != button_q) begin
          level_d  = target;
          button_d = target;
          if (!bounce_en) begin
            done_d = 1'b1;
          end else if (BOUNCES == 0) begin
            busy_d   = 1'b1;
            settle_d = SETTLE_LOAD;
            state_d  = StSettle;
          end else begin
            busy_d  = 1'b1;
            hold_d  = seg_len;
            tgl_d   = '0;
            state_d = StBounce;
          end
        end
      end

      StBounce: begin
        hold_d = hold_q - HOLD_ONE;
        if (hold_q == HOLD_ONE) begin
          hold_d   = seg_len;
          tgl_d    = tgl_q + TGL_ONE;
          button_d = ~button_q;
          // Even toggle count, so this lands back on the accepted level.
          if (tgl_q == TGL_LAST) begin
            button_d = level_q;
            settle_d = SETTLE_LOAD;
            state_d  = StSettle;
          end
        end
      end

      StSettle: begin
        settle_d = settle_q - SETTLE_ONE;
        if (settle_q == SETTLE_ONE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      button_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      level_q  <= 1'b0;
      hold_q   <= '0;
      tgl_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      button_q <= button_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      tgl_q    <= tgl_d;
      settle_q <= settle_d;
    end
  end

  assign button = button_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
